// File: rtl/counter_run_controller.sv
// Run/load sequencer for the 8-digit counter: debounces the front-panel controls,
// gates count ticks by run state and centralises terminal-count handling.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | stopped, counter cleared or untouched, waiting for Start/Load
// RUNNING | prescaler active, Count_tick issued every TICK_DIV cycles
// PAUSED  | counter holds its value; Start resumes, Stop clears to IDLE
// LOADING | single cycle presenting Load_strobe and clamped Load_data
module counter_run_controller #(
  parameter int unsigned TICK_DIV        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_COUNT       = 99_999_999,
  parameter int unsigned COUNT_WIDTH     = 27
) (
  input  logic                   Clock_100MHz,
  input  logic                   Clear,
  input  logic                   Start_btn,
  input  logic                   Stop_btn,
  input  logic                   Load_btn,
  input  logic                   Dir_sw,
  input  logic                   Terminal_stop,
  input  logic [COUNT_WIDTH-1:0] Load_value,
  input  logic [COUNT_WIDTH-1:0] Count,
  output logic                   Count_tick,
  output logic                   Load_strobe,
  output logic [COUNT_WIDTH-1:0] Load_data,
  output logic                   Clear_count,
  output logic                   Up_down,
  output logic                   Terminal,
  output logic                   Running,
  output logic [1:0]             State
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_LOADING = 2'd3
  } state_t;

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0]     PRESC_ONE  = PRESC_W'(1);
  localparam logic [DB_W-1:0]        DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]        DB_ONE     = DB_W'(1);
  localparam logic [COUNT_WIDTH-1:0] MAX_C      = COUNT_WIDTH'(MAX_COUNT);

  // Bit order of the conditioned inputs: {dir, load, stop, start}; dir idles high.
  localparam logic [3:0] COND_INIT = 4'b1000;

  logic [3:0]      raw_in;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      deb;
  logic [2:0]      deb_prev;
  logic [DB_W-1:0] db_cnt [4];

  state_t               state;
  logic [PRESC_W-1:0]   presc;
  logic                 start_ev;
  logic                 stop_ev;
  logic                 load_ev;
  logic                 at_terminal;
  logic [COUNT_WIDTH-1:0] load_clamped;

  assign raw_in = {Dir_sw, Load_btn, Stop_btn, Start_btn};

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      sync1    <= COND_INIT;
      sync2    <= COND_INIT;
      deb      <= COND_INIT;
      deb_prev <= COND_INIT[2:0];
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1    <= raw_in;
      sync2    <= sync1;
      deb_prev <= deb[2:0];
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  assign start_ev = deb[0] & ~deb_prev[0];
  assign stop_ev  = deb[1] & ~deb_prev[1];
  assign load_ev  = deb[2] & ~deb_prev[2];

  assign at_terminal  = Up_down ? (Count == MAX_C) : (Count == '0);
  assign load_clamped = (Load_value > MAX_C) ? MAX_C : Load_value;

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      state       <= ST_IDLE;
      presc       <= '0;
      Count_tick  <= 1'b0;
      Load_strobe <= 1'b0;
      Load_data   <= '0;
      Clear_count <= 1'b0;
      Up_down     <= 1'b1;
      Terminal    <= 1'b0;
      Running     <= 1'b0;
    end else begin
      Count_tick  <= 1'b0;
      Load_strobe <= 1'b0;
      Clear_count <= 1'b0;
      Terminal    <= 1'b0;

      // Direction is frozen for the whole run so the counter never reverses mid-run.
      if (state != ST_RUNNING) begin
        Up_down <= deb[3];
      end

      unique case (state)
        ST_IDLE: begin
          if (load_ev) begin
            state       <= ST_LOADING;
            Load_strobe <= 1'b1;
            Load_data   <= load_clamped;
          end else if (start_ev) begin
            state   <= ST_RUNNING;
            presc   <= '0;
            Running <= 1'b1;
          end
        end

        ST_RUNNING: begin
          if (load_ev) begin
            state       <= ST_LOADING;
            Load_strobe <= 1'b1;
            Load_data   <= load_clamped;
            Running     <= 1'b0;
          end else if (stop_ev) begin
            state   <= ST_PAUSED;
            Running <= 1'b0;
          end else if (presc == PRESC_LAST) begin
            presc <= '0;
            if (at_terminal) begin
              Terminal <= 1'b1;
              if (Terminal_stop) begin
                state   <= ST_PAUSED;
                Running <= 1'b0;
              end else begin
                Count_tick <= 1'b1;
              end
            end else begin
              Count_tick <= 1'b1;
            end
          end else begin
            presc <= presc + PRESC_ONE;
          end
        end

        ST_PAUSED: begin
          if (load_ev) begin
            state       <= ST_LOADING;
            Load_strobe <= 1'b1;
            Load_data   <= load_clamped;
          end else if (stop_ev) begin
            state       <= ST_IDLE;
            Clear_count <= 1'b1;
          end else if (start_ev) begin
            state   <= ST_RUNNING;
            presc   <= '0;
            Running <= 1'b1;
          end
        end

        ST_LOADING: begin
          state <= ST_PAUSED;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign State = state;

endmodule

// File: tb/tb_counter_run_controller.sv
// Directed bench for counter_run_controller with TICK_DIV=4 and DEBOUNCE_CYCLES=3.
// A button change is seen by the FSM on the 6th rising edge after it is driven.
module tb_counter_run_controller;

  localparam int CW = 27;
  localparam logic [CW-1:0] MAXV = 27'd99_999_999;

  logic          clk = 1'b0;
  logic          clear;
  logic          start_btn;
  logic          stop_btn;
  logic          load_btn;
  logic          dir_sw;
  logic          terminal_stop;
  logic [CW-1:0] load_value;
  logic [CW-1:0] count;
  logic          count_tick;
  logic          load_strobe;
  logic [CW-1:0] load_data;
  logic          clear_count;
  logic          up_down;
  logic          terminal;
  logic          running;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_run_controller #(
    .TICK_DIV(4),
    .DEBOUNCE_CYCLES(3),
    .MAX_COUNT(99_999_999),
    .COUNT_WIDTH(CW)
  ) dut (
    .Clock_100MHz (clk),
    .Clear        (clear),
    .Start_btn    (start_btn),
    .Stop_btn     (stop_btn),
    .Load_btn     (load_btn),
    .Dir_sw       (dir_sw),
    .Terminal_stop(terminal_stop),
    .Load_value   (load_value),
    .Count        (count),
    .Count_tick   (count_tick),
    .Load_strobe  (load_strobe),
    .Load_data    (load_data),
    .Clear_count  (clear_count),
    .Up_down      (up_down),
    .Terminal     (terminal),
    .Running      (running),
    .State        (state)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; start_btn = 1'b1; stop_btn = 1'b1; load_btn = 1'b1; dir_sw = 1'b1;
    terminal_stop = 1'b0; load_value = 27'd42; count = 27'd5;
    cyc(2);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if ({count_tick, load_strobe, clear_count, terminal, running} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {count_tick, load_strobe, clear_count, terminal, running}); end
    checks++; if (up_down !== 1'b1) begin errors++; $display("FAIL reset_up_down got %0d want 1", up_down); end
    checks++; if (load_data !== 27'd0) begin errors++; $display("FAIL reset_load_data got %0d want 0", load_data); end
    clear = 1'b0;
    cyc(5);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_early_state got %0d want 0", state); end
    cyc(1);
    checks++; if (state !== 2'd3 || load_strobe !== 1'b1) begin
      errors++; $display("FAIL reset_held_load got state %0d strobe %0d want 3 1", state, load_strobe); end
    checks++; if (load_data !== 27'd42) begin errors++; $display("FAIL reset_load_data_42 got %0d want 42", load_data); end
    cyc(1);
    checks++; if (state !== 2'd2 || load_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_to_paused got state %0d strobe %0d want 2 0", state, load_strobe); end
    cyc(6);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL reset_single_event got %0d want 2", state); end
    start_btn = 1'b0; stop_btn = 1'b0; load_btn = 1'b0;
    cyc(8);
  endtask

  task automatic test_stop_clear;
    stop_btn = 1'b1;
    cyc(5);
    checks++; if (state !== 2'd2 || clear_count !== 1'b0) begin
      errors++; $display("FAIL stop_clear_early got state %0d clr %0d want 2 0", state, clear_count); end
    cyc(1);
    checks++; if (state !== 2'd0 || clear_count !== 1'b1) begin
      errors++; $display("FAIL stop_clear got state %0d clr %0d want 0 1", state, clear_count); end
    cyc(1);
    checks++; if (clear_count !== 1'b0) begin errors++; $display("FAIL stop_clear_pulse got %0d want 0", clear_count); end
    stop_btn = 1'b0;
    cyc(8);
  endtask

  task automatic test_debounce;
    int exp_tick;
    start_btn = 1'b1;
    cyc(2);
    start_btn = 1'b0;
    cyc(8);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL debounce_glitch got %0d want 0", state); end
    start_btn = 1'b1;
    cyc(5);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL debounce_early got %0d want 0", state); end
    cyc(1);
    checks++; if (state !== 2'd1 || running !== 1'b1 || count_tick !== 1'b0) begin
      errors++; $display("FAIL debounce_start got state %0d run %0d tick %0d want 1 1 0", state, running, count_tick); end
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k == 2) start_btn = 1'b0;
      exp_tick = ((k % 4) == 0) ? 1 : 0;
      checks++; if (count_tick !== exp_tick[0]) begin
        errors++; $display("FAIL tick_cadence k=%0d got %0d want %0d", k, count_tick, exp_tick); end
    end
  endtask

  task automatic test_load_clamp;
    load_value = 27'd123_456_789;
    cyc(2);
    load_btn = 1'b1;
    cyc(5);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL load_early got %0d want 1", state); end
    cyc(1);
    checks++; if (state !== 2'd3 || load_strobe !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL load_enter got state %0d strobe %0d run %0d want 3 1 0", state, load_strobe, running); end
    checks++; if (load_data !== MAXV) begin errors++; $display("FAIL load_clamp got %0d want %0d", load_data, MAXV); end
    checks++; if (count_tick !== 1'b0) begin errors++; $display("FAIL load_tick_discard got %0d want 0", count_tick); end
    cyc(1);
    checks++; if (state !== 2'd2 || load_strobe !== 1'b0 || count_tick !== 1'b0) begin
      errors++; $display("FAIL load_exit got state %0d strobe %0d tick %0d want 2 0 0", state, load_strobe, count_tick); end
    load_btn = 1'b0;
    cyc(8);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL load_hold_paused got %0d want 2", state); end
  endtask

  task automatic test_terminal;
    count = MAXV; terminal_stop = 1'b1;
    start_btn = 1'b1;
    cyc(6);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL term_up_run got %0d want 1", state); end
    start_btn = 1'b0;
    cyc(3);
    checks++; if (state !== 2'd1 || terminal !== 1'b0) begin
      errors++; $display("FAIL term_up_early got state %0d term %0d want 1 0", state, terminal); end
    cyc(1);
    checks++; if (terminal !== 1'b1 || count_tick !== 1'b0 || state !== 2'd2 || running !== 1'b0) begin
      errors++; $display("FAIL term_up_stop got term %0d tick %0d state %0d run %0d want 1 0 2 0", terminal, count_tick, state, running); end
    cyc(1);
    checks++; if (terminal !== 1'b0) begin errors++; $display("FAIL term_pulse got %0d want 0", terminal); end
    cyc(8);

    terminal_stop = 1'b0;
    start_btn = 1'b1;
    cyc(6);
    start_btn = 1'b0;
    cyc(4);
    checks++; if (terminal !== 1'b1 || count_tick !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL term_up_wrap got term %0d tick %0d state %0d want 1 1 1", terminal, count_tick, state); end
    cyc(1);
    checks++; if (terminal !== 1'b0 || count_tick !== 1'b0) begin
      errors++; $display("FAIL term_wrap_pulse got term %0d tick %0d want 0 0", terminal, count_tick); end
    cyc(3);
    checks++; if (terminal !== 1'b1 || count_tick !== 1'b1) begin
      errors++; $display("FAIL term_wrap_again got term %0d tick %0d want 1 1", terminal, count_tick); end
    stop_btn = 1'b1;
    cyc(6);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL term_stop_pause got %0d want 2", state); end
    stop_btn = 1'b0;
    dir_sw = 1'b0;
    cyc(8);
    checks++; if (up_down !== 1'b0) begin errors++; $display("FAIL dir_down_paused got %0d want 0", up_down); end

    count = 27'd0; terminal_stop = 1'b1;
    start_btn = 1'b1;
    cyc(6);
    start_btn = 1'b0;
    cyc(4);
    checks++; if (terminal !== 1'b1 || count_tick !== 1'b0 || state !== 2'd2) begin
      errors++; $display("FAIL term_down_stop got term %0d tick %0d state %0d want 1 0 2", terminal, count_tick, state); end
    cyc(8);
    terminal_stop = 1'b0;
    start_btn = 1'b1;
    cyc(6);
    start_btn = 1'b0;
    cyc(4);
    checks++; if (terminal !== 1'b1 || count_tick !== 1'b1 || state !== 2'd1) begin
      errors++; $display("FAIL term_down_wrap got term %0d tick %0d state %0d want 1 1 1", terminal, count_tick, state); end
    count = MAXV;
    cyc(4);
    checks++; if (terminal !== 1'b0 || count_tick !== 1'b1) begin
      errors++; $display("FAIL term_down_at_max got term %0d tick %0d want 0 1", terminal, count_tick); end
    stop_btn = 1'b1;
    cyc(6);
    stop_btn = 1'b0;
    dir_sw = 1'b1; count = 27'd5;
    cyc(8);
    checks++; if (state !== 2'd2 || up_down !== 1'b1) begin
      errors++; $display("FAIL term_restore got state %0d dir %0d want 2 1", state, up_down); end
  endtask

  task automatic test_priority_direction;
    start_btn = 1'b1;
    cyc(6);
    start_btn = 1'b0;
    cyc(8);
    dir_sw = 1'b0;
    cyc(8);
    checks++; if (up_down !== 1'b1) begin errors++; $display("FAIL dir_frozen_load got %0d want 1", up_down); end
    load_value = 27'd500;
    start_btn = 1'b1; stop_btn = 1'b1; load_btn = 1'b1;
    cyc(6);
    checks++; if (state !== 2'd3 || load_strobe !== 1'b1 || load_data !== 27'd500) begin
      errors++; $display("FAIL prio_load got state %0d strobe %0d data %0d want 3 1 500", state, load_strobe, load_data); end
    cyc(1);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL prio_paused got %0d want 2", state); end
    cyc(1);
    checks++; if (up_down !== 1'b0) begin errors++; $display("FAIL dir_after_load got %0d want 0", up_down); end
    start_btn = 1'b0; stop_btn = 1'b0; load_btn = 1'b0;
    cyc(8);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL prio_release got %0d want 2", state); end

    dir_sw = 1'b1;
    cyc(8);
    start_btn = 1'b1;
    cyc(6);
    checks++; if (state !== 2'd1 || up_down !== 1'b1) begin
      errors++; $display("FAIL dir_run_start got state %0d dir %0d want 1 1", state, up_down); end
    start_btn = 1'b0; dir_sw = 1'b0;
    cyc(8);
    checks++; if (up_down !== 1'b1) begin errors++; $display("FAIL dir_frozen_stop got %0d want 1", up_down); end
    stop_btn = 1'b1;
    cyc(6);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL dir_stop_pause got %0d want 2", state); end
    cyc(1);
    checks++; if (up_down !== 1'b0) begin errors++; $display("FAIL dir_after_stop got %0d want 0", up_down); end
    stop_btn = 1'b0; dir_sw = 1'b1;
    cyc(8);
  endtask

  task automatic test_reset_running;
    int bad_ticks;
    int bad_state;
    bad_ticks = 0;
    bad_state = 0;
    start_btn = 1'b1;
    cyc(6);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_run_start got %0d want 1", state); end
    start_btn = 1'b0;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    checks++; if (state !== 2'd0 || {count_tick, load_strobe, clear_count, terminal, running} !== 5'b0) begin
      errors++; $display("FAIL rst_run_clear got state %0d strobes %b want 0 00000", state, {count_tick, load_strobe, clear_count, terminal, running}); end
    checks++; if (load_data !== 27'd0 || up_down !== 1'b1) begin
      errors++; $display("FAIL rst_run_data got data %0d dir %0d want 0 1", load_data, up_down); end
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (count_tick !== 1'b0) bad_ticks++;
      if (state !== 2'd0) bad_state++;
    end
    checks++; if (bad_ticks != 0 || bad_state != 0) begin
      errors++; $display("FAIL rst_run_after got tick_cycles %0d state_cycles %0d want 0 0", bad_ticks, bad_state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stop_clear();
    test_debounce();
    test_load_clamp();
    test_terminal();
    test_priority_direction();
    test_reset_running();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_run_controller.md
Name: counter_run_controller

Overview:
Run/load sequencer for the 8-digit 0..99_999_999 counter datapath. It debounces the front-panel Start/Stop/Load buttons and the direction switch, and runs a small FSM (IDLE/RUNNING/PAUSED/LOADING). It then drives the counter with single-cycle count ticks, load strobes with clamped data, a clear strobe and a direction level. It replaces the free-running 1 Hz divider: ticks are gated by the run state, and terminal-count handling is centralised here.

Parameters:
TICK_DIV, 100_000_000, Clock_100MHz cycles per Count_tick (1 Hz at 100 MHz); must be >= 2
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced level changes (10 ms)
MAX_COUNT, 99_999_999, terminal value for up-counting and clamp value for load data
COUNT_WIDTH, 27, width of the count and load buses

Ports:
Clock_100MHz  in  1  system clock; all logic on the rising edge
Clear  in  1  synchronous active-high reset
Start_btn  in  1  raw asynchronous push-button
Stop_btn  in  1  raw asynchronous push-button
Load_btn  in  1  raw asynchronous push-button
Dir_sw  in  1  raw slide switch; 1 = up, 0 = down
Terminal_stop  in  1  1 = pause at terminal count; 0 = let the counter wrap
Load_value  in  COUNT_WIDTH  value to preset into the counter
Count  in  COUNT_WIDTH  current counter value, fed back from the counter
Count_tick  out  1  one-cycle increment/decrement enable to the counter
Load_strobe  out  1  one-cycle load enable to the counter
Load_data  out  COUNT_WIDTH  clamped preset value; valid while Load_strobe is high
Clear_count  out  1  one-cycle counter clear to 0
Up_down  out  1  direction level to the counter
Terminal  out  1  one-cycle pulse when a tick occurs at the terminal value
Running  out  1  high while the FSM is in RUNNING
State  out  2  FSM state: IDLE=0, RUNNING=1, PAUSED=2, LOADING=3

Behaviour:
- All outputs are registered.
- Reset (Clear=1 at a clock edge) forces the following, with priority over everything and in any state:
  - State=IDLE.
  - Count_tick, Load_strobe, Clear_count, Terminal, Running = 0.
  - Load_data = 0 and Up_down = 1.
  - Prescaler = 0 and all debounce counters = 0.
  - Debounced buttons = 0; debounced Dir = 1.
  - Pending events are dropped.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer.
  - The debounced level flips only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any matching cycle resets that input's counter to 0.
  - A press event is a one-cycle pulse on the 0->1 edge of a debounced button. Holding a button yields exactly one event.
- Event priority when several press events fall in the same cycle: Load > Stop > Start.
- FSM transitions:
  - IDLE: Start -> RUNNING. Load -> LOADING.
  - RUNNING: Load -> LOADING. Stop -> PAUSED. Terminal stop (see below) -> PAUSED.
  - PAUSED: Start -> RUNNING. Load -> LOADING. Stop -> IDLE, with Clear_count=1 for one cycle.
  - LOADING: always lasts exactly one cycle, then -> PAUSED. Load_strobe=1 during that cycle; Load_data = min(Load_value, MAX_COUNT).
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUNNING; it holds in all other states.
  - It is set to 0 on every entry into RUNNING.
  - Count_tick is asserted for one cycle in the cycle after the prescaler equals TICK_DIV-1. The first tick after entering RUNNING therefore appears TICK_DIV cycles after entry.
  - Count_tick is never asserted outside RUNNING. A tick decision made in the same cycle as a Stop/Load event is discarded.
- Direction: Up_down follows debounced Dir in IDLE, PAUSED and LOADING. It is frozen in RUNNING; a switch change takes effect at the next exit from RUNNING.
- Terminal handling, evaluated at the tick decision using the Count input:
  - Terminal condition: (Up_down=1 and Count=MAX_COUNT) or (Up_down=0 and Count=0).
  - On a terminal condition, Terminal=1 for one cycle.
  - Terminal_stop=1: Count_tick is suppressed, so the counter holds at the terminal value, and the FSM -> PAUSED.
  - Terminal_stop=0: Count_tick is issued, the counter wraps, and the FSM stays in RUNNING.
- Running = (State==RUNNING). State always mirrors the registered FSM state.
- Clear_count and Load_strobe are mutually exclusive and never coincide with Count_tick.

Test Plan:
(Bench parameters: TICK_DIV=4, DEBOUNCE_CYCLES=3.)
1. Reset: Clear=1 for 2 cycles with all buttons high -> State=0, all strobes 0, Up_down=1, Load_data=0. After release, the held buttons produce exactly one debounced Load event -> LOADING, then PAUSED.
2. Debounce: Start_btn high 2 cycles, then low -> State stays IDLE. Start_btn high 8 cycles -> State=1, Count_tick pulses every 4 cycles, first pulse 4 cycles after entry, exactly one Start event.
3. Load: in RUNNING, Load_value=123_456_789 and Load pressed -> Load_strobe one cycle with Load_data=99_999_999, no Count_tick, State=3 then 2.
4. Terminal: RUNNING, Up_down=1, Count=99_999_999.
   - Terminal_stop=1 -> Terminal pulse, Count_tick stays 0, State=2.
   - Terminal_stop=0 -> Terminal and Count_tick pulse together, State stays 1.
   - Repeat down-counting with Count=0.
5. Priority and direction: Start+Stop+Load events in the same cycle while RUNNING -> LOADING, then PAUSED. Toggling Dir_sw in RUNNING leaves Up_down unchanged until Stop, after which Up_down=0.
6. Reset and clear: Clear=1 while RUNNING with prescaler=2 -> next cycle State=0, no Count_tick ever issued from the old prescaler. Separately, Stop pressed in PAUSED -> Clear_count one cycle, State=0.
